// File: rtl/checkpoint_commit_reader_pkg.sv
// Shared checkpoint types, commit geometry and small helpers for the commit-side reader.
// Latency: n/a (types, constants and a combinational helper function only).
// Backpressure: n/a.
package checkpoint_commit_reader_pkg;

    localparam int COMMIT_WIDTH        = 4;
    localparam int CHECKPOINT_ID_WIDTH = 4;

    // Snapshot handed back to rename/RAT on a mispredict restore.
    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ghr;
        logic [7:0]  rat_tag;
        logic [7:0]  fl_head;
    } checkpoint_t;

    typedef enum logic [1:0] {
        CKPT_RD_IDLE    = 2'd0,
        CKPT_RD_RESTORE = 2'd1,
        CKPT_RD_FLUSH   = 2'd2
    } ckpt_reader_state_t;

    // Population count of a 64-bit vector.
    function automatic logic [6:0] count_one(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/checkpoint_commit_reader_priority_finder.sv
// Lowest-set-bit finder: index of the lowest asserted request plus a found flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req (W request bits) -> idx (lowest set index, 0 when none), found.
module checkpoint_commit_reader_priority_finder #(
    parameter int W     = 4,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the last hit written is the lowest slot.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/checkpoint_commit_reader.sv
// Commit-side checkpoint reader: in-order pops, mispredict restore, then buffer flush.
// Latency: pops same cycle; restore_valid +1 cycle after mispredict, flush +2 cycles.
// Backpressure: reader_rob_ready is low outside IDLE; commit inputs are ignored then.
//
// Ports: clk/rst (async, active-low); rob_* commit slot inputs; commit_cpbuf_id/pop/flush
// to the checkpoint buffer with cpbuf_commit_data as its zero-latency read data;
// restore_valid/restore_data to rename/RAT; flush_done marks the end of a flush.
// Optional: define CHECKPOINT_COMMIT_READER_PERF_EN to add 64-bit saturating
// perf_pop_count and perf_restore_count outputs.
module checkpoint_commit_reader
    import checkpoint_commit_reader_pkg::*;
#(
    parameter int COMMIT_W = COMMIT_WIDTH,
    parameter int ID_W     = CHECKPOINT_ID_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [COMMIT_W-1:0]              rob_commit_valid,
    input  logic [COMMIT_W-1:0]              rob_ckpt_valid,
    input  logic [COMMIT_W-1:0][ID_W-1:0]    rob_ckpt_id,
    input  logic [COMMIT_W-1:0]              rob_ckpt_mispredict,
    input  logic                             rob_exception_flush,
    output logic                             reader_rob_ready,
    output logic [COMMIT_W-1:0][ID_W-1:0]    commit_cpbuf_id,
    input  checkpoint_t [COMMIT_W-1:0]       cpbuf_commit_data,
    output logic [COMMIT_W-1:0]              commit_cpbuf_pop,
    output logic                             commit_cpbuf_flush,
    output logic                             restore_valid,
    output checkpoint_t                      restore_data,
    output logic                             flush_done
`ifdef CHECKPOINT_COMMIT_READER_PERF_EN
    ,
    output logic [63:0]                      perf_pop_count,
    output logic [63:0]                      perf_restore_count
`endif
);

    localparam int IDX_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    ckpt_reader_state_t state_q, state_d;
    checkpoint_t        restore_q, restore_d;

    logic [COMMIT_W-1:0] mis_vec;
    logic [IDX_W-1:0]    mis_idx;
    logic                mis_found;
    logic                idle_act;

    // Reset also forces ready low so every output reads 0 while rst is held.
    assign idle_act = rst && (state_q == CKPT_RD_IDLE);
    assign mis_vec  = rob_commit_valid & rob_ckpt_mispredict;

    checkpoint_commit_reader_priority_finder #(
        .W     (COMMIT_W),
        .IDX_W (IDX_W)
    ) u_mis_finder (
        .req   (mis_vec),
        .idx   (mis_idx),
        .found (mis_found)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CKPT_RD_IDLE;
            restore_q <= '0;
        end else begin
            state_q   <= state_d;
            restore_q <= restore_d;
        end
    end

    // ---------------- next state ----------------
    // A mispredict wins over a simultaneous exception; the flush that follows
    // the restore covers the exception as well.
    always_comb begin
        state_d   = state_q;
        restore_d = restore_q;
        case (state_q)
            CKPT_RD_IDLE: begin
                if (mis_found) begin
                    state_d   = CKPT_RD_RESTORE;
                    restore_d = cpbuf_commit_data[mis_idx];
                end else if (rob_exception_flush) begin
                    state_d = CKPT_RD_FLUSH;
                end
            end
            CKPT_RD_RESTORE: state_d = CKPT_RD_FLUSH;
            CKPT_RD_FLUSH:   state_d = CKPT_RD_IDLE;
            default:         state_d = CKPT_RD_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Slots younger than the first mispredict are left for the ROB to squash;
    // the mispredicting slot itself still pops its checkpoint.
    always_comb begin
        commit_cpbuf_pop = '0;
        if (idle_act) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (!mis_found || (IDX_W'(i) <= mis_idx)) begin
                    commit_cpbuf_pop[i] = rob_commit_valid[i] & rob_ckpt_valid[i];
                end
            end
        end
    end

    always_comb begin
        reader_rob_ready   = idle_act;
        commit_cpbuf_id    = rst ? rob_ckpt_id : '0;
        restore_valid      = (state_q == CKPT_RD_RESTORE);
        restore_data       = restore_q;
        commit_cpbuf_flush = (state_q == CKPT_RD_FLUSH);
        flush_done         = (state_q == CKPT_RD_FLUSH);
    end

`ifdef CHECKPOINT_COMMIT_READER_PERF_EN
    logic [63:0] pop_cnt_q, pop_cnt_d;
    logic [63:0] rst_cnt_q, rst_cnt_d;
    logic [64:0] pop_sum;

    always_comb begin
        pop_sum   = {1'b0, pop_cnt_q} + 65'(count_one(64'(commit_cpbuf_pop)));
        pop_cnt_d = pop_sum[64] ? '1 : pop_sum[63:0];
        rst_cnt_d = rst_cnt_q;
        if ((state_q == CKPT_RD_IDLE) && (state_d == CKPT_RD_RESTORE) && (rst_cnt_q != '1)) begin
            rst_cnt_d = rst_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_cnt_q <= '0;
            rst_cnt_q <= '0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign perf_pop_count     = pop_cnt_q;
    assign perf_restore_count = rst_cnt_q;
`endif

endmodule

// File: tb/tb_checkpoint_commit_reader.sv
// Bench for checkpoint_commit_reader: directed and random commit transactions
// checked against a slot-scan reference model; optional perf counters follow
// CHECKPOINT_COMMIT_READER_PERF_EN.
module tb_checkpoint_commit_reader;
    import checkpoint_commit_reader_pkg::*;

    localparam int CW = COMMIT_WIDTH;
    localparam int IW = CHECKPOINT_ID_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CW-1:0]          rob_commit_valid;
    logic [CW-1:0]          rob_ckpt_valid;
    logic [CW-1:0][IW-1:0]  rob_ckpt_id;
    logic [CW-1:0]          rob_ckpt_mispredict;
    logic                   rob_exception_flush;
    logic                   reader_rob_ready;
    logic [CW-1:0][IW-1:0]  commit_cpbuf_id;
    checkpoint_t [CW-1:0]   cpbuf_commit_data;
    logic [CW-1:0]          commit_cpbuf_pop;
    logic                   commit_cpbuf_flush;
    logic                   restore_valid;
    checkpoint_t            restore_data;
    logic                   flush_done;
`ifdef CHECKPOINT_COMMIT_READER_PERF_EN
    logic [63:0]            perf_pop_count;
    logic [63:0]            perf_restore_count;
`endif

    checkpoint_commit_reader dut (
        .clk                 (clk),
        .rst                 (rst),
        .rob_commit_valid    (rob_commit_valid),
        .rob_ckpt_valid      (rob_ckpt_valid),
        .rob_ckpt_id         (rob_ckpt_id),
        .rob_ckpt_mispredict (rob_ckpt_mispredict),
        .rob_exception_flush (rob_exception_flush),
        .reader_rob_ready    (reader_rob_ready),
        .commit_cpbuf_id     (commit_cpbuf_id),
        .cpbuf_commit_data   (cpbuf_commit_data),
        .commit_cpbuf_pop    (commit_cpbuf_pop),
        .commit_cpbuf_flush  (commit_cpbuf_flush),
        .restore_valid       (restore_valid),
        .restore_data        (restore_data),
        .flush_done          (flush_done)
`ifdef CHECKPOINT_COMMIT_READER_PERF_EN
        ,
        .perf_pop_count      (perf_pop_count),
        .perf_restore_count  (perf_restore_count)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] pop_total;
    logic [63:0] restore_total;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk slots oldest-first; every committing slot that owns a
    // checkpoint pops, and the walk stops after the first committing mispredict.
    function automatic logic [CW-1:0] model_pop(input logic [CW-1:0] cv, input logic [CW-1:0] ckv,
                                                input logic [CW-1:0] mp);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            if (cv[i] && ckv[i]) r[i] = 1'b1;
            if (cv[i] && mp[i]) break;
        end
        return r;
    endfunction

    function automatic int model_m(input logic [CW-1:0] cv, input logic [CW-1:0] mp);
        for (int i = 0; i < CW; i++) begin
            if (cv[i] && mp[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_random();
        rob_commit_valid    = CW'($urandom);
        rob_ckpt_valid      = CW'($urandom);
        rob_ckpt_mispredict = CW'($urandom);
        rob_exception_flush = 1'($urandom);
        for (int i = 0; i < CW; i++) begin
            rob_ckpt_id[i]       = IW'($urandom);
            cpbuf_commit_data[i] = {$urandom, $urandom};
        end
    endtask

    task automatic drive_zero();
        rob_commit_valid    = '0;
        rob_ckpt_valid      = '0;
        rob_ckpt_mispredict = '0;
        rob_exception_flush = 1'b0;
        rob_ckpt_id         = '0;
        cpbuf_commit_data   = '0;
    endtask

    task automatic check_perf(input string tag);
`ifdef CHECKPOINT_COMMIT_READER_PERF_EN
        check({tag, "_perf_pop"}, perf_pop_count, pop_total);
        check({tag, "_perf_restore"}, perf_restore_count, restore_total);
`else
        if (tag.len() == 0) $display("[TB] empty tag");
`endif
    endtask

    // Busy cycle: inputs are garbage and must be ignored.
    task automatic check_busy(input string tag, input logic exp_restore, input logic exp_flush);
        check({tag, "_ready"}, 64'(reader_rob_ready), 64'd0);
        check({tag, "_pop"}, 64'(commit_cpbuf_pop), 64'd0);
        check({tag, "_restore_valid"}, 64'(restore_valid), 64'(exp_restore));
        check({tag, "_flush"}, 64'(commit_cpbuf_flush), 64'(exp_flush));
        check({tag, "_flush_done"}, 64'(flush_done), 64'(exp_flush));
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic run_txn(input string tag, input logic [CW-1:0] cv, input logic [CW-1:0] ckv,
                           input logic [CW-1:0] mp, input logic exc);
        logic [CW-1:0] epop;
        int            m;
        checkpoint_t   exp_data;
        rob_commit_valid    = cv;
        rob_ckpt_valid      = ckv;
        rob_ckpt_mispredict = mp;
        rob_exception_flush = exc;
        for (int i = 0; i < CW; i++) begin
            rob_ckpt_id[i]       = IW'($urandom);
            cpbuf_commit_data[i] = {$urandom, $urandom};
        end
        epop     = model_pop(cv, ckv, mp);
        m        = model_m(cv, mp);
        exp_data = (m >= 0) ? cpbuf_commit_data[m] : restore_data;
        @(negedge clk);
        check({tag, "_ready"}, 64'(reader_rob_ready), 64'd1);
        check({tag, "_pop"}, 64'(commit_cpbuf_pop), 64'(epop));
        check({tag, "_id"}, 64'(commit_cpbuf_id), 64'(rob_ckpt_id));
        check({tag, "_restore_idle"}, 64'(restore_valid), 64'd0);
        check({tag, "_flush_idle"}, 64'(commit_cpbuf_flush), 64'd0);
        pop_total = pop_total + 64'($countones(epop));
        if (m >= 0) restore_total = restore_total + 64'd1;
        @(posedge clk); #1;
        if (m >= 0) begin
            drive_random();
            @(negedge clk);
            check_busy({tag, "_c1"}, 1'b1, 1'b0);
            check({tag, "_restore_data"}, restore_data, exp_data);
            @(posedge clk); #1;
            drive_random();
            @(negedge clk);
            check_busy({tag, "_c2"}, 1'b0, 1'b1);
            check({tag, "_restore_hold"}, restore_data, exp_data);
            @(posedge clk); #1;
        end else if (exc) begin
            drive_random();
            @(negedge clk);
            check_busy({tag, "_c1"}, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        drive_zero();
        @(negedge clk);
        check({tag, "_ready_back"}, 64'(reader_rob_ready), 64'd1);
        check({tag, "_restore_after"}, 64'(restore_valid), 64'd0);
        check({tag, "_flush_after"}, 64'(commit_cpbuf_flush), 64'd0);
        check_perf(tag);
        @(posedge clk); #1;
    endtask

    // Reset asserted at posedge+1, checks all outputs, releases, watches idle.
    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        drive_random();
        pop_total     = '0;
        restore_total = '0;
        @(negedge clk);
        check({tag, "_ready"}, 64'(reader_rob_ready), 64'd0);
        check({tag, "_pop"}, 64'(commit_cpbuf_pop), 64'd0);
        check({tag, "_id"}, 64'(commit_cpbuf_id), 64'd0);
        check({tag, "_restore_valid"}, 64'(restore_valid), 64'd0);
        check({tag, "_restore_data"}, restore_data, 64'd0);
        check({tag, "_flush"}, 64'(commit_cpbuf_flush), 64'd0);
        check({tag, "_flush_done"}, 64'(flush_done), 64'd0);
        check_perf(tag);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_zero();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({tag, "_post_ready"}, 64'(reader_rob_ready), 64'd1);
            check({tag, "_post_restore"}, 64'(restore_valid), 64'd0);
            check({tag, "_post_flush"}, 64'(commit_cpbuf_flush), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [CW-1:0] cv, ckv, mp;
        drive_zero();
        pop_total     = '0;
        restore_total = '0;
        #2;
        @(posedge clk); #1;
        reset_pulse("reset");

        run_txn("t1_no_mis", 4'b0111, 4'b0101, 4'b0000, 1'b0);
        run_txn("t2_mis1", 4'b1111, 4'b1111, 4'b0010, 1'b0);
        run_txn("t3_mis_two", 4'b1111, 4'b1111, 4'b1010, 1'b0);
        run_txn("t4_exc", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        run_txn("t5_mis_exc", 4'b1111, 4'b1111, 4'b0100, 1'b1);
        run_txn("t_ckv0", 4'b0011, 4'b0001, 4'b0010, 1'b0);
        run_txn("t_mis_nocommit", 4'b0101, 4'b1111, 4'b0010, 1'b0);

        for (int n = 0; n < 40; n++) begin
            cv  = CW'($urandom);
            ckv = CW'($urandom);
            mp  = CW'($urandom & $urandom & $urandom);
            run_txn("rand", cv, ckv, mp, ($urandom_range(0, 3) == 0));
        end

        // Reset while the restore is pending.
        rob_commit_valid    = 4'b1111;
        rob_ckpt_valid      = 4'b1111;
        rob_ckpt_mispredict = 4'b0001;
        rob_exception_flush = 1'b0;
        @(negedge clk);
        check("t6_mis_pop", 64'(commit_cpbuf_pop), 64'h1);
        @(posedge clk); #1;
        reset_pulse("t6_rst_restore");

        // Reset while the flush is pending.
        rob_commit_valid    = 4'b0001;
        rob_ckpt_valid      = 4'b0001;
        rob_ckpt_mispredict = 4'b0000;
        rob_exception_flush = 1'b1;
        @(negedge clk);
        check("t6_exc_pop", 64'(commit_cpbuf_pop), 64'h1);
        @(posedge clk); #1;
        reset_pulse("t6_rst_flush");

        run_txn("t7_after_rst", 4'b1111, 4'b1111, 4'b0010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/checkpoint_commit_reader.md
Name: checkpoint_commit_reader

Overview:
Commit-side consumer of the checkpoint buffer. It sits between the ROB commit stage and the checkpoint buffer's commit read/pop/flush interface. It retires checkpoints in order as branches commit. On a committed mispredict it latches that branch's checkpoint, presents it to rename/RAT for restore, then flushes the buffer.

Parameters:
COMMIT_W, `COMMIT_WIDTH (default 4), number of commit slots per cycle.
ID_W, `CHECKPOINT_ID_WIDTH (default 4), checkpoint id width.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
rob_commit_valid  input  COMMIT_W  slot i retires this cycle
rob_ckpt_valid  input  COMMIT_W  retiring slot i owns a checkpoint
rob_ckpt_id  input  ID_W x COMMIT_W  checkpoint id of slot i
rob_ckpt_mispredict  input  COMMIT_W  slot i is a mispredicted branch
rob_exception_flush  input  1  exception flush request from commit
reader_rob_ready  output  1  commit inputs accepted this cycle
commit_cpbuf_id  output  ID_W x COMMIT_W  read/pop address per slot (= rob_ckpt_id)
cpbuf_commit_data  input  checkpoint_t x COMMIT_W  combinational read data
commit_cpbuf_pop  output  COMMIT_W  pop mask
commit_cpbuf_flush  output  1  buffer pointer reset pulse
restore_valid  output  1  restore_data valid (1-cycle pulse)
restore_data  output  checkpoint_t  checkpoint to restore into rename/RAT
flush_done  output  1  1-cycle pulse when flush sequence completes

Behaviour:
- FSM states: IDLE, RESTORE, FLUSH. Reset state is IDLE. On reset, all outputs are 0 and restore_data is 0.
- reader_rob_ready = (state == IDLE). While it is low, all rob_* inputs are ignored and pop is 0.
- IDLE, slot masking:
  - m = index of the lowest slot with rob_commit_valid & rob_ckpt_mispredict.
  - pop[i] = rob_commit_valid[i] & rob_ckpt_valid[i] for i <= m; all slots if no mispredict.
  - Slots above m are never popped; the ROB must squash them.
  - The mispredicting slot's own checkpoint is popped.
- IDLE with a mispredict present:
  - restore_reg <= cpbuf_commit_data[m] in the same cycle (zero-latency read), then go to RESTORE.
  - Mispredict takes priority over a simultaneous rob_exception_flush; the exception is absorbed by the following flush.
- IDLE, exception only: go to FLUSH. Pops for valid slots are still issued that cycle.
- RESTORE: restore_valid = 1 and restore_data = restore_reg for exactly one cycle, then go to FLUSH.
- FLUSH: commit_cpbuf_flush = 1 and flush_done = 1 for exactly one cycle, then go to IDLE.
- Mispredict-to-flush latency: restore_valid appears 1 cycle after the mispredict cycle; flush appears 2 cycles after.
- Slots with rob_ckpt_valid = 0 never pop, even when committing.
- Popping an empty buffer is tolerated (the buffer holds its read pointer); the reader does not track occupancy.
- Asynchronous reset asserted mid-RESTORE or mid-FLUSH: return immediately to IDLE with outputs 0; no flush pulse is emitted.
- restore_data holds its last value outside RESTORE; consumers qualify it with restore_valid.

Optional Feature:
CHECKPOINT_COMMIT_READER_PERF_EN
- Defined:
  - Adds outputs perf_pop_count and perf_restore_count, each 64 bits.
  - pop_count increments by popcount(commit_cpbuf_pop) each cycle.
  - restore_count increments on each RESTORE entry.
  - Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- checkpoint_t, COMMIT_WIDTH and CHECKPOINT_ID_WIDTH come from the shared config/common package.
- Add the FSM state enum (ckpt_reader_state_t) to common.
- Reuse the existing count_one for the perf pop count.
- One natural sub-module: priority_finder (lowest-set-bit index plus valid), used to locate m.

Test Plan:
1. Commit valid=4'b0111, ckpt_valid=4'b0101, no mispredict -> pop=4'b0101; ready stays 1; no restore or flush.
2. Commit valid=4'b1111, ckpt_valid=4'b1111, mispredict=4'b0010, data[1]=D -> cycle0 pop=4'b0011 and ready then 0; cycle1 restore_valid=1 with restore_data=D; cycle2 flush=1 and flush_done=1; cycle3 ready=1.
3. Mispredict=4'b1010 -> m=1, pop=4'b0011, restore_data=data[1] (not data[3]).
4. rob_exception_flush=1 with valid=4'b0001 and ckpt_valid=4'b0001 -> pop=4'b0001; next cycle flush=1 with no restore_valid; ready returns the following cycle.
5. Mispredict and exception in the same cycle -> exactly one restore pulse, then exactly one flush pulse.
6. Reset asserted the cycle after a mispredict -> restore_valid and flush never pulse; state is IDLE and ready=1 after reset release. With PERF_EN: after scenario 2, pop_count=2 and restore_count=1.
